// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line settings, divider helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_CLK_HZ    = 100_000_000;
    localparam int UART_BAUD      = 115_200;
    localparam int UART_OVS       = 16;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_t;

    // clk cycles per oversample tick, truncated
    function automatic int uart_div(input int clk_hz, input int baud, input int ovs);
        return clk_hz / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Received-byte delivery bus with valid/ready handshake and status pulses.
// Latency: n/a (wires only).
// Backpressure: i_ready from the consumer; o_valid/o_data held until accepted.
interface uart_rx_core_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] o_data;
    logic                      o_valid;
    logic                      i_ready;
    logic                      o_frame_err;
    logic                      o_overrun;
    logic                      o_busy;

    modport master (
        output o_data,
        output o_valid,
        output o_frame_err,
        output o_overrun,
        output o_busy,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        input  o_frame_err,
        input  o_overrun,
        input  o_busy,
        output i_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Baud/oversample tick generator: free-running 0..DIV-1 counter, synchronous clear.
// Latency: first tick DIV cycles after i_clr drops.
// Backpressure: none; tick is a single-cycle strobe.
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic arst_i,
    input  logic i_clr,
    output logic o_tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // Divider counter; clear holds phase at zero so the next tick lands exactly DIV cycles out
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, 16x oversampled, single mid-bit sample, framing/overrun flags.
// Latency: byte valid on the cycle after the mid-stop-bit tick (~9.5 bit periods after start edge).
// Backpressure: o_valid held until i_ready; a byte finishing while one is still held is dropped and flagged.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ = UART_CLK_HZ,
    parameter int BAUD   = UART_BAUD,
    parameter int OVS    = UART_OVS,
    parameter int DIV    = uart_div(CLK_HZ, BAUD, OVS)
) (
    input  logic             clk,
    input  logic             arst_i,
    input  logic             i_rx,
    uart_rx_core_if.master   rx_bus
);

    localparam int SW = $clog2(OVS);
    localparam int BW = $clog2(UART_DATA_BITS);

    localparam logic [SW-1:0] SMP_MID  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] SMP_END  = SW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

    logic                      r_rx_meta;
    logic                      r_rx_s;
    uart_rx_state_t            r_state;
    logic [SW-1:0]             r_smp_cnt;
    logic [BW-1:0]             r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_frame_err;
    logic                      r_overrun;
    logic                      r_busy;

    logic                      w_tick;
    logic                      w_tick_clr;

    // Two-flop synchronizer; resets to idle-high so reset never looks like a start edge
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Holding the divider at zero while idle aligns sampling phase to the detected start edge
    assign w_tick_clr = (r_state == ST_IDLE);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk    (clk),
        .arst_i (arst_i),
        .i_clr  (w_tick_clr),
        .o_tick (w_tick)
    );

    // Frame FSM plus output handshake; all outputs registered here
    always_ff @(posedge clk or posedge arst_i) begin
        if (arst_i) begin
            r_state     <= ST_IDLE;
            r_smp_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // Consumer take; a delivery in the same cycle overrides this below
            if (r_valid && rx_bus.i_ready) begin
                r_valid <= 1'b0;
            end

            unique case (r_state)
                ST_IDLE: begin
                    r_smp_cnt <= '0;
                    r_bit_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        if (r_smp_cnt == SMP_MID) begin
                            r_smp_cnt <= '0;
                            if (r_rx_s) begin
                                // line went back high before mid start bit: noise, not a frame
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= ST_DATA;
                            end
                        end else begin
                            r_smp_cnt <= r_smp_cnt + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        // OVS is a power of two, so the sample counter wraps to 0 by itself
                        r_smp_cnt <= r_smp_cnt + 1'b1;
                        if (r_smp_cnt == SMP_END) begin
                            r_shift   <= {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == BIT_LAST) begin
                                r_state <= ST_STOP;
                            end
                        end
                    end
                end

                ST_STOP: begin
                    if (w_tick) begin
                        r_smp_cnt <= r_smp_cnt + 1'b1;
                        if (r_smp_cnt == SMP_END) begin
                            if (r_rx_s) begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                if (!r_valid || rx_bus.i_ready) begin
                                    r_data  <= r_shift;
                                    r_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= ST_BREAK;
                            end
                        end
                    end
                end

                ST_BREAK: begin
                    // stay here while the line is low so a break cannot retrigger a frame
                    if (r_rx_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bus.o_data      = r_data;
    assign rx_bus.o_valid     = r_valid;
    assign rx_bus.o_frame_err = r_frame_err;
    assign rx_bus.o_overrun   = r_overrun;
    assign rx_bus.o_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed corner cases, a frame table, randomized frames.
// Runs at a faster line rate (8 clk per tick, 128 clk per bit) to keep simulation short.
// Consumer ready is driven by the bench; flags are counted by a monitor.
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int TB_CLK_HZ = 100_000_000;
    localparam int TB_BAUD   = 781_250;
    localparam int OVS       = 16;
    localparam int DIV       = TB_CLK_HZ / (TB_BAUD * OVS);
    localparam int BIT       = DIV * OVS;
    // rising edges from driving the start edge to the edge that delivers the byte:
    // 2 synchronizer + 1 detect, then half a start bit, 8 data bits and 1 stop bit of ticks
    localparam int DELIV_EDGES = 3 + DIV * (OVS / 2 + 9 * OVS);

    typedef struct {
        logic [7:0] din;
        bit         stop_ok;
        bit         exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    logic clk    = 1'b0;
    logic arst_i = 1'b0;
    logic i_rx   = 1'b1;

    uart_rx_core_if rx_bus ();

    uart_rx_core #(
        .CLK_HZ (TB_CLK_HZ),
        .BAUD   (TB_BAUD),
        .OVS    (OVS)
    ) dut (
        .clk    (clk),
        .arst_i (arst_i),
        .i_rx   (i_rx),
        .rx_bus (rx_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    int ferr0, ovr0, n_lat, kind, exp_ovr;
    logic [7:0] rb, held;
    logic       have;
    vec_t vecs[6];

    // Flag monitor, sampled shortly after each rising edge
    always begin
        @(posedge clk);
        #2;
        if (rx_bus.o_frame_err) ferr_cnt++;
        if (rx_bus.o_overrun)   ovr_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; drives one 8N1 frame, leaves the line at the stop level
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        i_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        i_rx = stop_ok;
        repeat (BIT) @(negedge clk);
    endtask

    // One-cycle ready pulse; valid must drop on the following cycle
    task automatic accept(input string name);
        rx_bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        check({name, " valid clears after accept"}, rx_bus.o_valid, 1'b0);
        @(negedge clk);
        rx_bus.i_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{din: 8'h00, stop_ok: 1'b1, exp_valid: 1'b1, exp_data: 8'h00, exp_ferr: 0};
        vecs[1] = '{din: 8'hFF, stop_ok: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_ferr: 0};
        vecs[2] = '{din: 8'h01, stop_ok: 1'b1, exp_valid: 1'b1, exp_data: 8'h01, exp_ferr: 0};
        vecs[3] = '{din: 8'h80, stop_ok: 1'b1, exp_valid: 1'b1, exp_data: 8'h80, exp_ferr: 0};
        vecs[4] = '{din: 8'hC3, stop_ok: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1};
        vecs[5] = '{din: 8'h7E, stop_ok: 1'b1, exp_valid: 1'b1, exp_data: 8'h7E, exp_ferr: 0};

        rx_bus.i_ready = 1'b0;
        arst_i = 1'b1;
        repeat (3) @(negedge clk);
        check("reset o_valid", rx_bus.o_valid, 1'b0);
        check("reset o_busy", rx_bus.o_busy, 1'b0);
        check("reset o_data", rx_bus.o_data, 8'h00);
        check("reset o_frame_err", rx_bus.o_frame_err, 1'b0);
        check("reset o_overrun", rx_bus.o_overrun, 1'b0);
        arst_i = 1'b0;
        idle_cycles(3);
        check("busy right after reset release", rx_bus.o_busy, 1'b0);
        idle_cycles(2000);
        check("idle o_valid", rx_bus.o_valid, 1'b0);
        check("idle o_busy", rx_bus.o_busy, 1'b0);
        check("idle frame_err pulses", ferr_cnt, 0);
        check("idle overrun pulses", ovr_cnt, 0);

        // 0xA5, consumer not ready: byte appears within 10 bit periods, not before 9
        n_lat = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (!rx_bus.o_valid && n_lat < 10 * BIT) begin
                    @(negedge clk);
                    n_lat++;
                end
                check("A5 valid within 10 bit periods", (n_lat < 10 * BIT), 1'b1);
                check("A5 not before 9 bit periods", (n_lat >= 9 * BIT), 1'b1);
            end
        join
        check("A5 data", rx_bus.o_data, 8'hA5);
        check("A5 valid held", rx_bus.o_valid, 1'b1);
        accept("A5");

        // short low glitch on an idle line
        ferr0 = ferr_cnt;
        i_rx = 1'b0;
        idle_cycles(40);
        i_rx = 1'b1;
        check("glitch seen as start", rx_bus.o_busy, 1'b1);
        idle_cycles(2 * BIT);
        check("glitch back to idle", rx_bus.o_busy, 1'b0);
        check("glitch no valid", rx_bus.o_valid, 1'b0);
        check("glitch no frame_err", ferr_cnt - ferr0, 0);

        // 0x3C with low stop bit, line held low, then a clean 0x81
        ferr0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        idle_cycles(5 * BIT);
        check("break holds busy", rx_bus.o_busy, 1'b1);
        check("break frame_err once", ferr_cnt - ferr0, 1);
        check("break no valid", rx_bus.o_valid, 1'b0);
        i_rx = 1'b1;
        idle_cycles(4);
        check("break released", rx_bus.o_busy, 1'b0);
        send_frame(8'h81, 1'b1);
        check("after break valid", rx_bus.o_valid, 1'b1);
        check("after break data", rx_bus.o_data, 8'h81);
        check("after break frame_err still once", ferr_cnt - ferr0, 1);
        accept("81");

        // back-to-back 0x11, 0x22 with no consumer: second is dropped
        ovr0 = ovr_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("overrun keeps data", rx_bus.o_data, 8'h11);
        check("overrun keeps valid", rx_bus.o_valid, 1'b1);
        check("overrun pulsed once", ovr_cnt - ovr0, 1);
        accept("ovr");

        // same pair, consumer takes 0x11 exactly on 0x22's delivery cycle
        send_frame(8'h11, 1'b1);
        check("pair2 first data", rx_bus.o_data, 8'h11);
        ovr0 = ovr_cnt;
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (DELIV_EDGES - 1) @(posedge clk);
                @(negedge clk);
                check("pre-delivery data", rx_bus.o_data, 8'h11);
                check("pre-delivery valid", rx_bus.o_valid, 1'b1);
                rx_bus.i_ready = 1'b1;
                @(posedge clk);
                #1;
                check("accept+deliver valid", rx_bus.o_valid, 1'b1);
                check("accept+deliver data", rx_bus.o_data, 8'h22);
                @(negedge clk);
                rx_bus.i_ready = 1'b0;
            end
        join
        check("accept+deliver no overrun", ovr_cnt - ovr0, 0);
        check("accept+deliver data held", rx_bus.o_data, 8'h22);
        accept("22");

        // reset in the middle of a 0xFF frame, with a stale byte pending
        send_frame(8'h33, 1'b1);
        check("pending before reset", rx_bus.o_valid, 1'b1);
        ferr0 = ferr_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                idle_cycles(3 * BIT);
                check("mid-frame busy", rx_bus.o_busy, 1'b1);
                #2 arst_i = 1'b1;
                #1;
                check("async reset clears busy", rx_bus.o_busy, 1'b0);
                check("async reset clears valid", rx_bus.o_valid, 1'b0);
                check("async reset clears data", rx_bus.o_data, 8'h00);
                idle_cycles(2);
                arst_i = 1'b0;
            end
        join
        idle_cycles(BIT);
        check("aborted frame no valid", rx_bus.o_valid, 1'b0);
        check("aborted frame idle", rx_bus.o_busy, 1'b0);
        check("aborted frame no frame_err", ferr_cnt - ferr0, 0);
        send_frame(8'h5A, 1'b1);
        check("post-reset valid", rx_bus.o_valid, 1'b1);
        check("post-reset data", rx_bus.o_data, 8'h5A);
        accept("5A");

        // frame table, consumer drains each good byte
        for (int i = 0; i < 6; i++) begin
            ferr0 = ferr_cnt;
            send_frame(vecs[i].din, vecs[i].stop_ok);
            i_rx = 1'b1;
            idle_cycles(2 * BIT);
            check("table valid", rx_bus.o_valid, vecs[i].exp_valid);
            check("table frame_err", ferr_cnt - ferr0, vecs[i].exp_ferr);
            check("table busy", rx_bus.o_busy, 1'b0);
            if (vecs[i].exp_valid) begin
                check("table data", rx_bus.o_data, vecs[i].exp_data);
                accept("table");
            end
        end

        // randomized traffic against a holding-register model
        have = 1'b0;
        held = 8'h00;
        for (int k = 0; k < 12; k++) begin
            rb      = 8'($urandom);
            kind    = int'($urandom_range(0, 5));
            ferr0   = ferr_cnt;
            ovr0    = ovr_cnt;
            exp_ovr = 0;
            if (kind == 0) begin
                i_rx = 1'b0;
                idle_cycles(int'($urandom_range(1, 40)));
                i_rx = 1'b1;
            end else begin
                send_frame(rb, kind != 1);
                i_rx = 1'b1;
                if (kind != 1) begin
                    if (!have) begin
                        have = 1'b1;
                        held = rb;
                    end else begin
                        exp_ovr = 1;
                    end
                end
            end
            idle_cycles(BIT + int'($urandom_range(0, BIT)));
            check("rnd busy", rx_bus.o_busy, 1'b0);
            check("rnd frame_err", ferr_cnt - ferr0, (kind == 1) ? 1 : 0);
            check("rnd overrun", ovr_cnt - ovr0, exp_ovr);
            check("rnd valid", rx_bus.o_valid, have);
            if (have) begin
                check("rnd data", rx_bus.o_data, held);
                if ($urandom_range(0, 2) != 0) begin
                    accept("rnd");
                    have = 1'b0;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial UART receiver. It is the receive-side counterpart of the sequencer→UART transmit path.
- Converts the asynchronous RsRx line (8N1, LSB first) into parallel bytes, delivered over a valid/ready handshake to the command/sequencer logic.
- Uses 16x oversampling with mid-bit sampling.
- Flags framing errors and overruns.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- OVS, 16, oversample ticks per bit (power of 2, ≥8).
- DIV, CLK_HZ/(BAUD*OVS) = 54, clk cycles per oversample tick (integer truncation; ≥2).

Ports:
- clk  in  1  system clock, 100 MHz
- arst_i  in  1  reset, asynchronous, active-high
- i_rx  in  1  raw serial input (RsRx), idle high, asynchronous to clk
- i_ready  in  1  consumer accepts o_data when o_valid=1
- o_data  out  8  received byte, stable while o_valid=1
- o_valid  out  1  byte available; held until accepted
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_overrun  out  1  one-cycle pulse: byte completed while previous byte still unaccepted
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: every flop clears asynchronously on arst_i=1.
  - Synchronizer flops and the sampled rx reset to 1 (line idle).
  - o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
  - FSM goes to IDLE; tick counter, sample counter and bit counter go to 0.
  - Reset mid-frame aborts the frame; no output is produced for it.
- Input synchronizer:
  - 2-FF synchronizer on i_rx; rx_s is the second stage.
  - All decisions use rx_s, which gives 2-cycle input latency.
- Tick generator:
  - Counter runs 0..DIV-1; tick=1 on the cycle it wraps.
  - The counter is forced to 0 in IDLE so sampling phase aligns to the start edge.
- Sample counter (4 bits for OVS=16): counts ticks within a bit.
- FSM states and transitions:
  - IDLE: on rx_s=0, go to START with sample cnt=0.
  - START: when the tick brings sample cnt to OVS/2-1 (mid start bit), check rx_s.
    - rx_s=1: glitch; go to IDLE with no flags.
    - rx_s=0: go to DATA with sample cnt=0 and bit cnt=0.
  - DATA: every OVS ticks (mid-bit), shift rx_s into shift reg bit 7 (right shift, LSB first).
    - After the 8th bit, go to STOP.
  - STOP: after OVS ticks (mid stop bit), check rx_s.
    - rx_s=1: good frame; deliver (see below) and go to IDLE.
    - rx_s=0: pulse o_frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This prevents a break or low line from retriggering.
- Delivery: happens on the clk cycle after the stop-bit sample tick.
  - If o_valid=0: o_data←shift reg, o_valid←1.
  - If o_valid=1 and i_ready=1 in that same cycle: the old byte is consumed, the new byte is loaded, o_valid stays 1, no overrun.
  - If o_valid=1 and i_ready=0: new byte dropped, o_data unchanged, o_overrun pulses for 1 cycle.
- Handshake:
  - o_valid clears on the cycle after i_ready=1 while o_valid=1, unless a delivery occurs in that cycle.
  - i_ready while o_valid=0 is ignored.
  - o_data is never modified while o_valid=1 except by the simultaneous accept+deliver case.
- Sampling: a single sample at mid-bit; no majority vote.
- Timing: one bit period is DIV*OVS = 864 clk cycles (default). Baud tolerance is ±3% end-of-frame drift.
- Back-to-back frames: a start edge can be detected immediately on return to IDLE, i.e. after the middle of the stop bit.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding: IDLE, START, DATA, STOP, BREAK.
  - Default CLK_HZ and BAUD constants.
  - UART_DATA_BITS=8.
- One natural sub-module: uart_baud_tick (DIV counter with synchronous clear; outputs tick). It is reusable by the transmit side at OVS=1.
- Synchronizer stays inline.

Test Plan:
- Reset then idle line for 2000 cycles → o_valid=0, o_busy=0, no flag pulses ever.
- Send 0xA5 (8N1, 864 cycles/bit), i_ready=0 → o_valid=1 with o_data=0xA5 within 10 bit periods of the start edge. Raise i_ready for 1 cycle → o_valid=0 on the next cycle.
- Low glitch of 200 cycles on idle line → FSM returns to IDLE, o_valid stays 0, o_frame_err stays 0.
- Send 0x3C with stop bit held low, then line held low for 5000 cycles, then high, then send 0x81 → o_frame_err pulses once, no valid for 0x3C, then o_data=0x81 with o_valid=1.
- Send 0x11 then 0x22 back-to-back with i_ready=0 → o_data stays 0x11 and o_overrun pulses once at 0x22's delivery. Repeat with i_ready=1 asserted exactly at 0x22's delivery cycle → o_data=0x22, o_valid stays 1, no overrun.
- Assert arst_i mid-DATA of 0xFF, release, then send 0x5A → no output for the aborted frame; o_data=0x5A with o_valid=1.
